// File: rtl/counter_4bit.sv
// Free-running WIDTH-bit up-counter with count enable and asynchronous active-high clear.
// One-cycle latency from en to cnt; tc is combinational so stages can be chained en-to-tc.
module counter_4bit #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             en,
   output logic [WIDTH-1:0] cnt,
   output logic             tc
);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;

   // Natural WIDTH-bit overflow supplies the wrap to zero.
   always_comb begin
      cnt_d = cnt_q;
      if (en) begin
         cnt_d = cnt_q + WIDTH'(1);
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;
   assign tc  = en & (&cnt_q);

endmodule

// File: tb/tb_counter_4bit.sv
// Randomized bench for counter_4bit at WIDTH=4 and WIDTH=3 against an integer reference model.
module tb_counter_4bit;

   logic       clk = 1'b1;
   logic       clr4, en4, clr3, en3;
   logic [3:0] cnt4;
   logic [2:0] cnt3;
   logic       tc4, tc3;

   int n_vec = 0;
   int n_err = 0;
   int m4    = 0;
   int m3    = 0;

   always #5 clk = ~clk;

   counter_4bit #(.WIDTH(4)) dut4 (.clk(clk), .clr(clr4), .en(en4), .cnt(cnt4), .tc(tc4));
   counter_4bit #(.WIDTH(3)) dut3 (.clk(clk), .clr(clr3), .en(en3), .cnt(cnt3), .tc(tc3));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Starts and ends on a falling edge; optional mid-cycle clear pulse per instance.
   task automatic step(input logic e4, input logic e3, input logic p4, input logic p3);
      en4 = e4;
      en3 = e3;
      #1;
      chk("tc4_pre", {31'd0, tc4}, {31'd0, en4 && m4 == 15});
      chk("tc3_pre", {31'd0, tc3}, {31'd0, en3 && m3 == 7});
      if (p4 || p3) begin
         #1;
         if (p4) clr4 = 1'b1;
         if (p3) clr3 = 1'b1;
         #1;
         if (p4) begin
            m4 = 0;
            chk("cnt4_async_clr", {28'd0, cnt4}, 0);
            chk("tc4_async_clr", {31'd0, tc4}, 0);
         end
         if (p3) begin
            m3 = 0;
            chk("cnt3_async_clr", {29'd0, cnt3}, 0);
         end
         #1;
         if (p4) clr4 = 1'b0;
         if (p3) clr3 = 1'b0;
      end
      @(posedge clk);
      #1;
      if (clr4) m4 = 0; else if (en4) m4 = (m4 + 1) % 16;
      if (clr3) m3 = 0; else if (en3) m3 = (m3 + 1) % 8;
      chk("cnt4", {28'd0, cnt4}, m4);
      chk("cnt3", {29'd0, cnt3}, m3);
      @(negedge clk);
   endtask

   initial begin
      clr4 = 1'b1;
      en4  = 1'b0;
      clr3 = 1'b1;
      en3  = 1'b0;
      #1;
      chk("reset_cnt4", {28'd0, cnt4}, 0);
      chk("reset_tc4", {31'd0, tc4}, 0);
      chk("reset_cnt3", {29'd0, cnt3}, 0);
      @(negedge clk);
      clr4 = 1'b0;
      clr3 = 1'b0;

      // Continuous count: two full wraps of the 4-bit counter, four of the 3-bit one.
      for (int i = 0; i < 32; i++) begin
         step(1'b1, 1'b1, 1'b0, 1'b0);
         chk("seq4", {28'd0, cnt4}, (i + 1) % 16);
         chk("seq3", {29'd0, cnt3}, (i + 1) % 8);
      end

      // Enable gating: count to 5, hold for three cycles, then resume.
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
      chk("hold5", {28'd0, cnt4}, 5);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      chk("resume6", {28'd0, cnt4}, 6);

      // Async clear at 9 between edges, then the next enabled edge gives 1.
      while (m4 != 9) step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b0);
      chk("after_clr", {28'd0, cnt4}, 1);

      // Clear priority over enable for four edges.
      clr4 = 1'b1;
      clr3 = 1'b1;
      for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
      clr4 = 1'b0;
      clr3 = 1'b0;
      step(1'b1, 1'b1, 1'b0, 1'b0);
      chk("post_prio4", {28'd0, cnt4}, 1);

      // Random enables with occasional clear pulses.
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0,
              $urandom_range(0, 29) == 0, $urandom_range(0, 29) == 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no completion, expected completion by 200000");
      $fatal(1);
   end

endmodule
